// File: rtl/eth_idma_req_arb_if.sv
// Handshake bundle between the Ethernet TX/RX DMA requesters, the shared
// iDMA port and the request arbiter. The arbiter uses the slave view and
// the surrounding logic (or a bench) uses the master view.
interface eth_idma_req_arb_if #(
   parameter int unsigned ReqWidth = 128,
   parameter int unsigned RspWidth = 64
);
   logic [ReqWidth-1:0] tx_req_i;
   logic                tx_req_valid_i;
   logic                tx_req_ready_o;
   logic [ReqWidth-1:0] rx_req_i;
   logic                rx_req_valid_i;
   logic                rx_req_ready_o;
   logic [RspWidth-1:0] tx_rsp_o;
   logic                tx_rsp_valid_o;
   logic                tx_rsp_ready_i;
   logic [RspWidth-1:0] rx_rsp_o;
   logic                rx_rsp_valid_o;
   logic                rx_rsp_ready_i;
   logic [ReqWidth-1:0] idma_req_o;
   logic                idma_req_valid_o;
   logic                idma_req_ready_i;
   logic [RspWidth-1:0] idma_rsp_i;
   logic                idma_rsp_valid_i;
   logic                idma_rsp_ready_o;

   modport slave (
      input  tx_req_i, tx_req_valid_i, rx_req_i, rx_req_valid_i,
      input  tx_rsp_ready_i, rx_rsp_ready_i,
      input  idma_req_ready_i, idma_rsp_i, idma_rsp_valid_i,
      output tx_req_ready_o, rx_req_ready_o,
      output tx_rsp_o, tx_rsp_valid_o, rx_rsp_o, rx_rsp_valid_o,
      output idma_req_o, idma_req_valid_o, idma_rsp_ready_o
   );

   modport master (
      output tx_req_i, tx_req_valid_i, rx_req_i, rx_req_valid_i,
      output tx_rsp_ready_i, rx_rsp_ready_i,
      output idma_req_ready_i, idma_rsp_i, idma_rsp_valid_i,
      input  tx_req_ready_o, rx_req_ready_o,
      input  tx_rsp_o, tx_rsp_valid_o, rx_rsp_o, rx_rsp_valid_o,
      input  idma_req_o, idma_req_valid_o, idma_rsp_ready_o
   );
endinterface

// File: rtl/eth_idma_req_arb.sv
// Round-robin arbiter sharing one iDMA request/response port between the
// Ethernet TX and RX DMA engines. Requests pass through combinationally;
// an order FIFO of source IDs steers the in-order responses back.
module eth_idma_req_arb #(
   parameter int unsigned ReqWidth       = 128,
   parameter int unsigned RspWidth       = 64,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   eth_idma_req_arb_if.slave                   bus,
   output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
   output logic                                busy_o,
   output logic                                err_o
);
   localparam int unsigned PtrWidth = $clog2(MaxOutstanding);
   localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

   // Idle: free to arbitrate. Locked: a request is presented and waiting.
   typedef enum logic {ArbIdle, ArbLocked} arbState_e;

   arbState_e             state_q, state_d;
   logic                  lockSrc_q, lockSrc_d;
   logic                  lastGrant_q, lastGrant_d;
   logic [MaxOutstanding-1:0] order_q;
   logic [PtrWidth-1:0]   wrPtr_q, rdPtr_q;
   logic [CntWidth-1:0]   count_q;
   logic                  err_q;

   logic                  grantSrc;
   logic                  grantValid;
   logic                  fifoFull;
   logic                  fifoEmpty;
   logic                  headSrc;
   logic                  rspReady;
   logic                  reqFire;
   logic                  rspFire;
   logic                  strayRsp;
   logic [ReqWidth-1:0]   reqPayload;
   logic [RspWidth-1:0]   rspPayload;

   function automatic logic [PtrWidth-1:0] nextPtr(input logic [PtrWidth-1:0] ptr);
      if (ptr == PtrWidth'(MaxOutstanding - 1)) begin
         return '0;
      end
      return ptr + PtrWidth'(1);
   endfunction

   assign fifoFull  = (count_q == CntWidth'(MaxOutstanding));
   assign fifoEmpty = (count_q == '0);
   assign headSrc   = order_q[rdPtr_q];

   // Grant selection and lock tracking; outputs are forced idle in reset.
   always_comb begin
      state_d    = state_q;
      lockSrc_d  = lockSrc_q;
      grantSrc   = 1'b0;
      grantValid = 1'b0;
      case (state_q)
         ArbLocked: begin
            grantSrc   = lockSrc_q;
            grantValid = lockSrc_q ? bus.rx_req_valid_i : bus.tx_req_valid_i;
         end
         default: begin
            if (bus.tx_req_valid_i && bus.rx_req_valid_i) begin
               grantSrc = ~lastGrant_q;
            end else begin
               grantSrc = bus.rx_req_valid_i;
            end
            grantValid = bus.tx_req_valid_i || bus.rx_req_valid_i;
         end
      endcase
      grantValid = grantValid && !fifoFull && rst_ni;
      if (grantValid && !bus.idma_req_ready_i) begin
         state_d   = ArbLocked;
         lockSrc_d = grantSrc;
      end else if (grantValid) begin
         state_d = ArbIdle;
      end
   end

   assign reqFire     = grantValid && bus.idma_req_ready_i;
   assign lastGrant_d = reqFire ? grantSrc : lastGrant_q;
   assign reqPayload  = grantSrc ? bus.rx_req_i : bus.tx_req_i;
   assign rspPayload  = bus.idma_rsp_i;

   assign bus.idma_req_o       = reqPayload;
   assign bus.idma_req_valid_o = grantValid;
   assign bus.tx_req_ready_o   = rst_ni && !fifoFull && !grantSrc && bus.idma_req_ready_i;
   assign bus.rx_req_ready_o   = rst_ni && !fifoFull &&  grantSrc && bus.idma_req_ready_i;

   assign rspReady = rst_ni && (fifoEmpty || (headSrc ? bus.rx_rsp_ready_i : bus.tx_rsp_ready_i));
   assign rspFire  = bus.idma_rsp_valid_i && rspReady && !fifoEmpty;
   assign strayRsp = bus.idma_rsp_valid_i && rspReady && fifoEmpty;

   assign bus.idma_rsp_ready_o = rspReady;
   assign bus.tx_rsp_o         = rspPayload;
   assign bus.rx_rsp_o         = rspPayload;
   assign bus.tx_rsp_valid_o   = rst_ni && !fifoEmpty && !headSrc && bus.idma_rsp_valid_i;
   assign bus.rx_rsp_valid_o   = rst_ni && !fifoEmpty &&  headSrc && bus.idma_rsp_valid_i;

   assign outstanding_o = count_q;
   assign busy_o        = (count_q != '0) || grantValid;
   assign err_o         = err_q;

   // Arbiter state: lock and last grant; reset favours RX on the first tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ArbIdle;
         lockSrc_q   <= 1'b0;
         lastGrant_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lockSrc_q   <= lockSrc_d;
         lastGrant_q <= lastGrant_d;
      end
   end

   // Order FIFO: push source ID on request handshake, pop on response handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         order_q <= '0;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (reqFire) begin
            order_q[wrPtr_q] <= grantSrc;
            wrPtr_q          <= nextPtr(wrPtr_q);
         end
         if (rspFire) begin
            rdPtr_q <= nextPtr(rdPtr_q);
         end
         if (reqFire && !rspFire) begin
            count_q <= count_q + CntWidth'(1);
         end else if (!reqFire && rspFire) begin
            count_q <= count_q - CntWidth'(1);
         end
      end
   end

   // Sticky error for a response that arrives with nothing outstanding.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (strayRsp) begin
         err_q <= 1'b1;
      end
   end
endmodule
